// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants and types for the audio sample FIFO slice.
//               AUDIO_SAMPLE_W      - default PCM sample width in bits
//               sample_t            - one PCM sample at the default width
//               AUDIO_FIFO_DEPTH_LOG2 - default log2 of FIFO depth
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  localparam int AUDIO_SAMPLE_W        = 16;
  localparam int AUDIO_FIFO_DEPTH_LOG2 = 4;

  typedef logic [AUDIO_SAMPLE_W-1:0] sample_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/audio_sample_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_fifo_if
// Description : Valid/ready push channel from the bus/CPU side into the
//               audio sample FIFO.
//               wr_data  - sample to push (producer -> FIFO)
//               wr_valid - push request  (producer -> FIFO)
//               wr_ready - FIFO can accept (FIFO -> producer)
//               master   - producer view; slave - FIFO view
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_sample_fifo_if
  import audio_pkg::*;
#(
  parameter int WIDTH = AUDIO_SAMPLE_W
) ();

  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );

endinterface : audio_sample_fifo_if
`default_nettype wire

// File: rtl/audio_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : audio_fifo_mem
// Description : Simple dual-port sample store, 2^DEPTH_LOG2 x WIDTH, with a
//               registered read port. The read register only loads on
//               rd_en, so rd_data holds the last read word between reads.
//   clk, rst_n       - clock, async active-low reset (read register only)
//   wr_en/addr/data  - write port
//   rd_en/addr       - read request
//   rd_data          - registered read data, 0 after reset
// Revision    : 1.0 - initial release
// ============================================================================
module audio_fifo_mem
  import audio_pkg::*;
#(
  parameter int WIDTH      = AUDIO_SAMPLE_W,
  parameter int DEPTH_LOG2 = AUDIO_FIFO_DEPTH_LOG2
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  wr_en,
  input  wire logic [DEPTH_LOG2-1:0] wr_addr,
  input  wire logic [WIDTH-1:0]      wr_data,
  input  wire logic                  rd_en,
  input  wire logic [DEPTH_LOG2-1:0] rd_addr,
  output logic      [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : audio_fifo_mem
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_fifo
// Description : Sample buffer between the bus/CPU and the DAC/PDM stage.
//               Words are pushed over a valid/ready channel and one word is
//               popped per rising edge of sample_clock, appearing on
//               sample_out one clk later together with sample_strobe.
//               A pop from an empty FIFO sets the sticky underrun flag.
//   clk, rst_n     - clock, async active-low reset
//   sample_clock   - divider output (synchronous to clk)
//   wr_bus         - push channel (slave modport)
//   flush          - synchronous clear of contents (beats push/pop)
//   underrun_clr   - clears underrun (a coincident new underrun wins)
//   sample_out     - held sample; sample_strobe - one-cycle period pulse
//   level          - stored word count; underrun - sticky starvation flag
//   irq_low        - low-watermark interrupt
// Optional    : define AUDIO_FIFO_LOW_IRQ_EN to enable irq_low
//               (registered level < LOW_WATER); otherwise irq_low is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH      = AUDIO_SAMPLE_W,
  parameter int DEPTH_LOG2 = AUDIO_FIFO_DEPTH_LOG2,
  parameter int LOW_WATER  = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  sample_clock,
  audio_sample_fifo_if.slave         wr_bus,
  input  wire logic                  flush,
  input  wire logic                  underrun_clr,
  output logic      [WIDTH-1:0]      sample_out,
  output logic                       sample_strobe,
  output logic      [DEPTH_LOG2:0]   level,
  output logic                       underrun,
  output logic                       irq_low
);

  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                sc_q;
  logic                rise;
  logic                empty;
  logic                full;
  logic                do_push;
  logic                do_pop;

  assign rise  = sample_clock & ~sc_q;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level = wr_ptr - rd_ptr;

  // wr_ready is based on current occupancy only; a pop in the same cycle
  // does not free a slot for a push while full.
  assign wr_bus.wr_ready = ~full;
  assign do_push         = wr_bus.wr_valid & ~full & ~flush;
  assign do_pop          = rise & ~empty & ~flush;

  // sc_q resets high so a sample_clock already high at reset release is not
  // mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q          <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sc_q          <= sample_clock;
      sample_strobe <= rise;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A flush-coincident rise counts as an empty pop.
      if (rise && (empty || flush)) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  // The memory's read register is the held output sample.
  audio_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (do_push),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (wr_bus.wr_data),
    .rd_en   (do_pop),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (sample_out)
  );

`ifdef AUDIO_FIFO_LOW_IRQ_EN
  localparam logic [DEPTH_LOG2:0] LOW_WATER_L = LOW_WATER[DEPTH_LOG2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_low <= 1'b0;
    end else begin
      irq_low <= (level < LOW_WATER_L);
    end
  end
`else
  assign irq_low = 1'b0;
`endif

endmodule : audio_sample_fifo
`default_nettype wire

// File: tb/tb_audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_sample_fifo
// Description : Self-checking bench for audio_sample_fifo. A queue-based
//               reference FIFO tracks expected contents, underrun and
//               irq_low; each sample period pushes the expected output
//               sample into a scoreboard queue that a separate monitor
//               drains whenever sample_strobe is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_sample_fifo;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sample_clock;
  logic flush;
  logic underrun_clr;
  sample_t    sample_out;
  logic       sample_strobe;
  logic [4:0] level;
  logic       underrun;
  logic       irq_low;

  audio_sample_fifo_if #(.WIDTH(AUDIO_SAMPLE_W)) bus ();

  audio_sample_fifo #(
    .WIDTH      (AUDIO_SAMPLE_W),
    .DEPTH_LOG2 (4),
    .LOW_WATER  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_clock  (sample_clock),
    .wr_bus        (bus),
    .flush         (flush),
    .underrun_clr  (underrun_clr),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .level         (level),
    .underrun      (underrun),
    .irq_low       (irq_low)
  );

  always #5 clk = ~clk;

  // Reference model state
  sample_t m_q[$];
  sample_t exp_q[$];
  sample_t m_sample;
  bit      m_under;
  bit      m_irq;
  bit      m_prev_sc;
  bit      mon_en;
  int      checks;
  int      errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clk cycle of stimulus; the model consumes the same inputs at the edge.
  task automatic step(input bit v, input sample_t d, input bit sc,
                      input bit fl, input bit clr);
    int  sz;
    bit  r;
    bus.wr_valid = v;
    bus.wr_data  = d;
    sample_clock = sc;
    flush        = fl;
    underrun_clr = clr;
    @(posedge clk);
    sz = m_q.size();
    r  = sc && !m_prev_sc;
    m_prev_sc = sc;
`ifdef AUDIO_FIFO_LOW_IRQ_EN
    m_irq = (sz < 4);
`else
    m_irq = 1'b0;
`endif
    if (r) begin
      if (!fl && sz != 0) m_sample = m_q.pop_front();
      exp_q.push_back(m_sample);
    end
    if (r && (fl || sz == 0)) m_under = 1'b1;
    else if (clr)             m_under = 1'b0;
    if (fl)                           m_q.delete();
    else if (v && sz < 16)            m_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
  endtask

  task automatic push(input sample_t d);
    step(1, d, 0, 0, 0);
  endtask

  task automatic pop_pulse();
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
  endtask

  // Monitor: per-cycle state checks plus scoreboard on every strobe.
  bit prev_strobe;
  initial begin
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        check("level",    {27'd0, level}, m_q.size());
        check("wr_ready", {31'd0, bus.wr_ready}, (m_q.size() < 16) ? 1 : 0);
        check("underrun", {31'd0, underrun}, {31'd0, m_under});
        check("irq_low",  {31'd0, irq_low},  {31'd0, m_irq});
        if (prev_strobe && sample_strobe) begin
          checks++; errors++;
          $display("FAIL strobe_spacing: strobe high on consecutive cycles at %0t", $time);
        end
        check("strobe", {31'd0, sample_strobe}, (exp_q.size() > 0) ? 1 : 0);
        if (exp_q.size() > 0) begin
          sample_t e;
          e = exp_q.pop_front();
          if (sample_strobe) check("sample_out_pop", {16'd0, sample_out}, {16'd0, e});
        end
        check("sample_out_held", {16'd0, sample_out}, {16'd0, m_sample});
        prev_strobe = sample_strobe;
      end
    end
  end

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    flush = 1'b0; underrun_clr = 1'b0;
    sample_clock = 1'b1;
    m_sample = '0; m_under = 1'b0; m_irq = 1'b0; m_prev_sc = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level",      {27'd0, level}, 0);
    check("reset_sample_out", {16'd0, sample_out}, 0);
    check("reset_strobe",     {31'd0, sample_strobe}, 0);
    check("reset_underrun",   {31'd0, underrun}, 0);
    check("reset_irq_low",    {31'd0, irq_low}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    // sample_clock held high across release: no pop, no underrun
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    idle(2);

    // Basic flow
    push(16'h1111); push(16'h2222); push(16'h3333);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 0, 0);
      idle(15);
    end

    // Full and wrap
    for (int i = 0; i < 17; i++) push(sample_t'(i));
    for (int i = 0; i < 8; i++) pop_pulse();
    for (int i = 16; i < 24; i++) push(sample_t'(i));
    for (int i = 0; i < 16; i++) pop_pulse();
    idle(2);

    // Underrun
    push(16'h2222);
    pop_pulse();
    pop_pulse();                    // empty pop, sample held at 0x2222
    step(0, '0, 1, 0, 1);           // clr with new underrun: set wins
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);           // plain clear
    idle(2);

    // Flush priority
    for (int i = 0; i < 5; i++) push(sample_t'(16'h0500 + i));
    step(1, 16'hABCD, 1, 1, 0);
    idle(3);
    step(0, '0, 0, 0, 1);

    // Watermark: 4 -> 3 -> 4
    for (int i = 0; i < 4; i++) push(sample_t'(16'h0400 + i));
    idle(2);
    pop_pulse();
    idle(2);
    push(16'h0404);
    idle(2);
    for (int i = 0; i < 4; i++) pop_pulse();
    step(0, '0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int  phase;
      bit  v;
      phase = (i / 300) % 3;
      v = (phase == 0) ? ($urandom_range(0, 9) < 8) :
          (phase == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1);
      step(v, sample_t'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
    end
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule : tb_audio_sample_fifo
`default_nettype wire

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Sample buffer directly downstream of the audio sample-rate divider.
- The bus/CPU side pushes PCM words through a valid/ready handshake.
- The block pops one word per rising edge of the divider's sample_clock output and presents it as a held sample to the DAC/PDM stage.
- Flags underrun so firmware can detect starvation.

Parameters:
- WIDTH, 16, PCM sample width in bits.
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- LOW_WATER, 4, level below which irq_low asserts (feature-dependent).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_clock  in  1  divider output, synchronous to clk; rising edge = one sample period.
- wr_data  in  WIDTH  sample to push.
- wr_valid  in  1  push request.
- wr_ready  out  1  FIFO can accept; equals !full.
- flush  in  1  one-cycle synchronous clear of FIFO contents.
- underrun_clr  in  1  clears sticky underrun.
- sample_out  out  WIDTH  current sample to the DAC, held between pops.
- sample_strobe  out  1  one-cycle pulse when a sample period begins.
- level  out  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2.
- underrun  out  1  sticky; a pop was attempted while empty.
- irq_low  out  1  low-watermark interrupt (see Optional Feature).

Behaviour:
- Reset (rst_n low, async):
  - Pointers and level go to 0; sample_out=0; sample_strobe=0; underrun=0; irq_low=0.
  - The edge-detect register resets to 1, so a high sample_clock after reset gives no spurious pop.
- Edge detect: sc_q <= sample_clock each cycle; rise = sample_clock & ~sc_q.
- Pop: on the cycle rise=1 (cycle N):
  - If not empty, read the head; sample_out takes the head and sample_strobe=1 in cycle N+1. Pop latency is one clk.
  - If empty, sample_out holds its previous value, sample_strobe still pulses in N+1, and underrun sets in N+1.
- Push: accepted when wr_valid && wr_ready; the word is written at that clk edge.
  - wr_ready depends only on current state; it does not look ahead to a same-cycle pop.
  - When full, pushes stall even if a pop occurs in the same cycle.
- Simultaneous push and pop, not full and not empty: both happen; level unchanged.
- Push into an empty FIFO in the same cycle as a rise: the pop sees empty, so underrun sets. The pushed word is stored; level becomes 1.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally.
  - full = MSBs differ and the rest are equal; empty = pointers equal.
  - level = wr_ptr - rd_ptr (modulo arithmetic).
- flush has priority over push and pop in the same cycle:
  - Pointers and level go to 0; any push that cycle is dropped.
  - sample_out is unchanged.
  - A coincident rise is treated as an empty pop: strobe and underrun set.
- underrun_clr and a new underrun in the same cycle: set wins.
- sample_strobe never asserts on consecutive cycles; minimum spacing is 2 cycles.
- No combinational path from inputs to sample_out or sample_strobe.

Optional Feature:
- Macro: AUDIO_FIFO_LOW_IRQ_EN.
- Defined: irq_low is registered, irq_low <= (level < LOW_WATER). It is level-sensitive and updates one cycle after level changes.
- Not defined: irq_low is tied to 0 and no comparator logic is generated. The port is always present.

Decomposition:
- Shared package audio_pkg holds:
  - the default sample width constant AUDIO_SAMPLE_W = 16;
  - the sample typedef sample_t;
  - the FIFO depth constant.
- One sub-module, audio_fifo_mem: simple dual-port array with registered read, DEPTH=2^DEPTH_LOG2 × WIDTH.
- Pointer, flag and edge logic stay in the top module.

Test Plan:
- Reset and edge: hold sample_clock=1 while releasing rst_n, with FIFO empty -> no sample_strobe, underrun stays 0.
- Basic flow: push 0x1111, 0x2222, 0x3333; apply 3 rises 16 clk apart -> sample_out=0x1111, 0x2222, 0x3333, each one cycle after its rise with a 1-cycle strobe; level steps 3→2→1→0.
- Full and wrap: push 16 words 0x0000..0x000F -> wr_ready=0 and level=16; a 17th push stalls. Pop 8, push 8 more (0x0010..0x0017), drain all -> output order 0x0000..0x0017 intact across pointer wrap.
- Underrun: empty FIFO, sample_out=0x2222, one rise -> sample_out stays 0x2222, strobe pulses, underrun=1. Pulse underrun_clr in the same cycle as the next empty rise -> underrun remains 1.
- Flush priority: level=5, then flush coincident with a push of 0xABCD and a rise -> level=0, 0xABCD dropped, sample_out unchanged, underrun=1.
- Watermark, with AUDIO_FIFO_LOW_IRQ_EN: level 4→3 -> irq_low rises one cycle later. Push back to 4 -> irq_low falls. Without the macro -> irq_low is 0 throughout.
